// File: rtl/video_raw_decoder.sv
// Composite two-wire receiver: separates line and field syncs from the
// sync/white levels and recovers 1-bit pixels with x/y coordinates.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   i_sync, i_white  raw composite levels (0 on i_sync = sync tip), async
//   o_hsync          one-cycle pulse per accepted line sync
//   o_vsync          one-cycle pulse at field start
//   o_locked         field timing locked (two field syncs seen)
//   o_valid          one-cycle strobe for o_pixel/o_pixel_x/o_pixel_y
//   o_pixel          sampled pixel value
//   o_pixel_x        active column 0..H_PIXELS-1
//   o_pixel_y        active row 0..V_LINES-1
module video_raw_decoder #(
  parameter int LINE_CLKS      = 1536,
  parameter int SYNC_MIN       = 48,
  parameter int BROAD_MIN      = 384,
  parameter int LINE_GUARD     = 1152,
  parameter int H_ACTIVE_START = 288,
  parameter int PIXEL_CLKS     = 3,
  parameter int H_PIXELS       = 320,
  parameter int V_ACTIVE_START = 32,
  parameter int V_LINES        = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sync,
  input  logic       i_white,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_locked,
  output logic       o_valid,
  output logic       o_pixel,
  output logic [8:0] o_pixel_x,
  output logic [7:0] o_pixel_y
);

  localparam logic [8:0]  LO_SYNC  = 9'(SYNC_MIN);
  localparam logic [8:0]  LO_BROAD = 9'(BROAD_MIN);
  localparam logic [11:0] H_GUARD  = 12'(LINE_GUARD);
  localparam logic [11:0] H_LOAD   = 12'(SYNC_MIN);
  localparam logic [11:0] H_TMO    = 12'(2 * LINE_CLKS - 1);
  localparam logic [11:0] H_PRE    = 12'(H_ACTIVE_START - 1);
  localparam logic [11:0] H_ST     = 12'(H_ACTIVE_START);
  localparam logic [11:0] H_END    =
    12'(H_ACTIVE_START + H_PIXELS * PIXEL_CLKS);
  localparam logic [9:0]  V_ST     = 10'(V_ACTIVE_START);
  localparam logic [9:0]  V_END    = 10'(V_ACTIVE_START + V_LINES);
  localparam logic [3:0]  PH_LAST  = 4'(PIXEL_CLKS - 1);
  localparam logic [3:0]  PH_MID   = 4'(PIXEL_CLKS / 2);

  logic       sync_m;
  logic       s_sync;
  logic       white_m;
  logic       s_white;
  logic [8:0] lo_cnt;
  logic [11:0] h_cnt;
  logic [9:0] line;
  logic [9:0] y_rel;
  logic       broad_seen;
  logic       pulse_acc;
  logic [1:0] vs_count;
  logic [3:0] ph;
  logic [8:0] px;

  logic accept;
  logic fsync;
  logic tmo;
  logic in_h;
  logic in_v;
  logic smp;

  assign accept = (lo_cnt == LO_SYNC) && (h_cnt >= H_GUARD);

  // A rise is the single cycle where s_sync is back high but lo_cnt
  // still holds the width of the pulse that just ended.
  assign fsync = s_sync && (lo_cnt != 9'd0) &&
                 (lo_cnt < LO_BROAD) && broad_seen &&
                 (pulse_acc || accept);

  assign tmo   = (h_cnt == H_TMO) && !accept;
  assign in_h  = (h_cnt >= H_ST) && (h_cnt < H_END);
  assign in_v  = (line >= V_ST) && (line < V_END);
  assign smp   = o_locked && in_h && in_v && (ph == PH_MID);
  assign y_rel = line - V_ST;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_m     <= 1'b1;
      s_sync     <= 1'b1;
      white_m    <= 1'b0;
      s_white    <= 1'b0;
      lo_cnt     <= 9'd0;
      h_cnt      <= 12'hfff;
      line       <= 10'h3ff;
      broad_seen <= 1'b0;
      pulse_acc  <= 1'b0;
      vs_count   <= 2'd0;
      ph         <= 4'd0;
      px         <= 9'd0;
      o_hsync    <= 1'b0;
      o_vsync    <= 1'b0;
      o_locked   <= 1'b0;
      o_valid    <= 1'b0;
      o_pixel    <= 1'b0;
      o_pixel_x  <= 9'd0;
      o_pixel_y  <= 8'd0;
    end else begin
      sync_m  <= i_sync;
      s_sync  <= sync_m;
      white_m <= i_white;
      s_white <= white_m;

      if (s_sync)
        lo_cnt <= 9'd0;
      else if (lo_cnt != LO_BROAD)
        lo_cnt <= lo_cnt + 9'd1;

      if (accept)
        h_cnt <= H_LOAD;
      else if (h_cnt != 12'hfff)
        h_cnt <= h_cnt + 12'd1;

      // Remembers that the pulse now in progress was a line sync,
      // so its trailing edge may mark the field start.
      if (s_sync)
        pulse_acc <= 1'b0;
      else if (accept)
        pulse_acc <= 1'b1;

      o_hsync <= accept;
      o_vsync <= fsync;

      if (fsync)
        line <= 10'd0;
      else if (tmo)
        line <= 10'h3ff;
      else if (accept && line != 10'h3ff)
        line <= line + 10'd1;

      if (fsync || tmo)
        broad_seen <= 1'b0;
      else if (lo_cnt == LO_BROAD)
        broad_seen <= 1'b1;

      if (tmo)
        vs_count <= 2'd0;
      else if (fsync && vs_count != 2'd2)
        vs_count <= vs_count + 2'd1;

      if (tmo)
        o_locked <= 1'b0;
      else if (fsync && vs_count != 2'd0)
        o_locked <= 1'b1;

      // ph/px track (h_cnt-H_ACTIVE_START) mod/div PIXEL_CLKS.
      if (h_cnt == H_PRE) begin
        ph <= 4'd0;
        px <= 9'd0;
      end else if (ph == PH_LAST) begin
        ph <= 4'd0;
        px <= px + 9'd1;
      end else begin
        ph <= ph + 4'd1;
      end

      o_valid <= smp;
      if (smp) begin
        o_pixel   <= s_sync & s_white;
        o_pixel_x <= px;
        o_pixel_y <= y_rel[7:0];
      end
    end
  end

endmodule

// File: tb/tb_video_raw_decoder.sv
// Bench for video_raw_decoder: drives composite pulse trains and grid
// lines, predicts events from line/field rules, compares event queues.
module tb_video_raw_decoder;

  localparam int VS = 4;
  localparam int VL = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_sync = 1'b1;
  logic       i_white = 1'b0;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_locked;
  logic       o_valid;
  logic       o_pixel;
  logic [8:0] o_pixel_x;
  logic [7:0] o_pixel_y;

  video_raw_decoder #(
    .V_ACTIVE_START(VS),
    .V_LINES(VL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_sync(i_sync),
    .i_white(i_white),
    .o_hsync(o_hsync),
    .o_vsync(o_vsync),
    .o_locked(o_locked),
    .o_valid(o_valid),
    .o_pixel(o_pixel),
    .o_pixel_x(o_pixel_x),
    .o_pixel_y(o_pixel_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] pk(int e, int x, int y, bit p);
    return {e, 12'(x), 12'(y), 7'd0, p};
  endfunction

  function automatic bit grid(int x, int y);
    return (x % 8 == 0) || (y % 8 == 0);
  endfunction

  int          hs_q[$];
  int          vs_q[$];
  logic [63:0] px_q[$];
  int          lock_fall = -1;
  logic        lock_d = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_hsync) hs_q.push_back(cyc);
      if (o_vsync) vs_q.push_back(cyc);
      if (o_valid)
        px_q.push_back(pk(cyc, int'(o_pixel_x),
                          int'(o_pixel_y), o_pixel));
      if (lock_d && !o_locked) lock_fall <= cyc;
    end
    lock_d <= o_locked;
  end

  // Reference model state, in raw-edge time.
  int          last_acc;
  int          mline;
  int          nvs;
  bit          mbroad;
  bit          mlock;
  int          exp_hs[$];
  int          exp_vs[$];
  logic [63:0] exp_px[$];

  task automatic model_init();
    last_acc = -1;
    mline    = 1023;
    nvs      = 0;
    mbroad   = 0;
    mlock    = 0;
    exp_hs.delete();
    exp_vs.delete();
    exp_px.delete();
    hs_q.delete();
    vs_q.delete();
    px_q.delete();
    lock_fall = -1;
  endtask

  // f: first clock edge that sees the low; w: low width in clocks.
  task automatic model(int f, int w);
    bit acc;
    int y;
    acc = (w >= 48) && (last_acc < 0 || f - last_acc >= 1105);
    if (w >= 384) mbroad = 1;
    if (acc) begin
      last_acc = f;
      exp_hs.push_back(f + 50);
      if (mline < 1023) mline++;
      if (w < 384 && mbroad) begin
        exp_vs.push_back(f + w + 2);
        mline  = 0;
        mbroad = 0;
        if (nvs < 2) nvs++;
        if (nvs == 2) mlock = 1;
      end
      if (mlock && mline >= VS && mline < VS + VL) begin
        y = mline - VS;
        for (int x = 0; x < 320; x++)
          exp_px.push_back(pk(f + 292 + 3 * x, x, y, grid(x, y)));
      end
    end
  endtask

  // One line: low for w clocks, then high; grid row drawn if row>=0.
  task automatic pulse(int w, int period, int row);
    model(cyc + 1, w);
    for (int i = 0; i < period; i++) begin
      i_sync  = (i >= w);
      i_white = (row >= 0) && (i >= 289) && (i < 289 + 960) &&
                grid((i - 289) / 3, row);
      @(posedge clk);
      #1;
    end
    i_white = 1'b0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    i_sync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_init();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_hs"}, o_hsync, 0);
    chk({tag, "_vs"}, o_vsync, 0);
    chk({tag, "_lock"}, o_locked, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_pix"}, o_pixel, 0);
    chk({tag, "_x"}, o_pixel_x, 0);
    chk({tag, "_y"}, o_pixel_y, 0);
  endtask

  task automatic cmp_all(string tag);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_hs_n"}, hs_q.size(), exp_hs.size());
    for (int i = 0; i < hs_q.size() && i < exp_hs.size(); i++)
      chk({tag, "_hs_t"}, hs_q[i], exp_hs[i]);
    chk({tag, "_vs_n"}, vs_q.size(), exp_vs.size());
    for (int i = 0; i < vs_q.size() && i < exp_vs.size(); i++)
      chk({tag, "_vs_t"}, vs_q[i], exp_vs[i]);
    chk({tag, "_px_n"}, px_q.size(), exp_px.size());
    for (int i = 0; i < px_q.size() && i < exp_px.size(); i++)
      chk({tag, "_px"}, px_q[i], exp_px[i]);
    hs_q.delete();
    vs_q.delete();
    px_q.delete();
    exp_hs.delete();
    exp_vs.delete();
    exp_px.delete();
  endtask

  task automatic field(int nl);
    for (int i = 0; i < 5; i++) pulse(650, 768, -1);
    for (int i = 0; i < 5; i++) pulse(56, 768, -1);
    chk("field_lock", o_locked, mlock);
    for (int k = 0; k < nl; k++)
      pulse($urandom_range(100, 130), 1536, k + 2 - VS);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    model_init();

    for (int i = 0; i < 5; i++)
      pulse($urandom_range(5, 47), 1536, -1);
    pulse(47, 1536, -1);
    cmp_all("glitch");
    chk("glitch_lock", o_locked, 0);

    do_reset();
    pulse(113, 1536, -1);
    pulse(48, 1536, -1);
    pulse($urandom_range(60, 140), 1104, -1);
    pulse($urandom_range(60, 140), 432, -1);
    pulse($urandom_range(60, 140), 1105, -1);
    pulse(113, 1536, -1);
    for (int i = 0; i < 2; i++)
      pulse($urandom_range(49, 383), 1536, -1);
    cmp_all("line");

    do_reset();
    for (int i = 0; i < 10; i++)
      pulse($urandom_range(50, 60), 768, -1);
    cmp_all("equal");

    do_reset();
    field(2);
    field(9);
    cmp_all("field");
    chk("field_locked", o_locked, 1);

    i_sync = 1'b1;
    repeat (3100) @(posedge clk);
    #1;
    chk("loss_fall", lock_fall, last_acc + 50 + 3024);
    chk("loss_lock", o_locked, 0);
    cmp_all("loss");

    i_sync = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    rst    = 1'b1;
    i_sync = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("midrst");
    rst = 1'b0;
    model_init();
    pulse(113, 1536, -1);
    cmp_all("postrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
